// File: rtl/way_select_mux.sv
// Way select multiplexer: picks one of WAYS packed words by binary index or one-hot
// hit vector, and queues the result in a 2-entry output FIFO.
module way_select_mux #(
   parameter int WAYS   = 8,
   parameter int WIDTH  = 1,
   parameter int ONEHOT = 0,
   localparam int SEL_W = (WAYS <= 2) ? 1 : $clog2(WAYS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SEL_W-1:0]        sel,
   input  logic [WAYS-1:0]         hit,
   input  logic [WAYS*WIDTH-1:0]   in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_way,
   output logic                    out_err,
   output logic                    out_multi
);

   localparam int ENT_W = WIDTH + SEL_W + 2;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t             state_reg, state_next;
   logic               in_ready_reg;
   logic [ENT_W-1:0]   head_reg, tail_reg, dec_entry;
   logic               load_head_dec, load_head_tail, load_tail;
   logic               accept, consume, valid_int;

   logic [WIDTH-1:0]   words [WAYS];
   logic [WIDTH-1:0]   dec_data;
   logic [SEL_W-1:0]   dec_way;
   logic               dec_err, dec_multi, hit_multi;

   for (genvar gi = 0; gi < WAYS; gi++) begin : g_words
      assign words[gi] = in_data[gi*WIDTH +: WIDTH];
   end

   // More than one bit set iff clearing the lowest set bit leaves something behind.
   assign hit_multi = |(hit & (hit - WAYS'(1)));

   always_comb begin
      dec_data  = '0;
      dec_way   = '0;
      dec_err   = 1'b1;
      dec_multi = 1'b0;
      if (ONEHOT == 0) begin
         dec_way = sel;
         for (int k = 0; k < WAYS; k++) begin
            if (sel == SEL_W'(k)) begin
               dec_data = words[k];
               dec_err  = 1'b0;
            end
         end
      end else begin
         // Walk downward so the lowest set index is the last one written.
         for (int k = WAYS - 1; k >= 0; k--) begin
            if (hit[k]) begin
               dec_data = words[k];
               dec_way  = SEL_W'(k);
            end
         end
         dec_err   = ~(|hit) | hit_multi;
         dec_multi = hit_multi;
      end
   end

   assign dec_entry = {dec_data, dec_way, dec_err, dec_multi};
   assign valid_int = (state_reg != EMPTY);
   assign accept    = in_valid & in_ready_reg;
   assign consume   = valid_int & out_ready;

   always_comb begin
      state_next     = state_reg;
      load_head_dec  = 1'b0;
      load_head_tail = 1'b0;
      load_tail      = 1'b0;
      case (state_reg)
         EMPTY: begin
            if (accept) begin
               state_next    = ONE;
               load_head_dec = 1'b1;
            end
         end
         ONE: begin
            if (accept && consume) begin
               load_head_dec = 1'b1;
            end else if (accept) begin
               state_next = FULL;
               load_tail  = 1'b1;
            end else if (consume) begin
               state_next = EMPTY;
            end
         end
         FULL: begin
            if (consume) begin
               state_next     = ONE;
               load_head_tail = 1'b1;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= EMPTY;
         in_ready_reg <= 1'b1;
      end else begin
         state_reg    <= state_next;
         in_ready_reg <= (state_next != FULL);
      end
   end

   // Entry storage needs no reset: the state register masks stale contents.
   always_ff @(posedge clk) begin
      if (load_head_dec) begin
         head_reg <= dec_entry;
      end else if (load_head_tail) begin
         head_reg <= tail_reg;
      end
      if (load_tail) begin
         tail_reg <= dec_entry;
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = valid_int;
   assign {out_data, out_way, out_err, out_multi} = head_reg & {ENT_W{valid_int}};

endmodule

// File: tb/tb_way_select_mux.sv
// Bench for way_select_mux: three instances (binary 8-way, binary 6-way, one-hot 8-way)
// checked cycle by cycle against an occupancy/queue model of the result stream.
module tb_way_select_mux;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [2:0]        iv, ir, ov, ordy, oe, om;
   logic [2:0][2:0]   sel_s, ow;
   logic [2:0][7:0]   hit_s, od;
   logic [2:0][63:0]  ind;

   int checks = 0;
   int passed = 0;
   logic [12:0] q[$];
   logic [7:0]  delivered[$];

   way_select_mux #(.WAYS(8), .WIDTH(8), .ONEHOT(0)) d0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .sel(sel_s[0]),
      .hit(hit_s[0]), .in_data(ind[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
      .out_data(od[0]), .out_way(ow[0]), .out_err(oe[0]), .out_multi(om[0]));

   way_select_mux #(.WAYS(6), .WIDTH(8), .ONEHOT(0)) d1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .sel(sel_s[1]),
      .hit(hit_s[1][5:0]), .in_data(ind[1][47:0]), .out_valid(ov[1]), .out_ready(ordy[1]),
      .out_data(od[1]), .out_way(ow[1]), .out_err(oe[1]), .out_multi(om[1]));

   way_select_mux #(.WAYS(8), .WIDTH(8), .ONEHOT(1)) d2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .sel(sel_s[2]),
      .hit(hit_s[2]), .in_data(ind[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
      .out_data(od[2]), .out_way(ow[2]), .out_err(oe[2]), .out_multi(om[2]));

   // Expected {data, way, err, multi} for a request, straight from the selection rules.
   function automatic logic [12:0] ref_entry(input int u, input logic [2:0] s,
                                             input logic [7:0] h, input logic [63:0] d);
      int w;
      int n;
      int k;
      w = (u == 1) ? 6 : 8;
      if (u == 2) begin
         n = $countones(h);
         if (n == 0) return {8'h00, 3'd0, 2'b10};
         k = 0;
         while (!h[k]) k++;
         return {d[k*8 +: 8], 3'(k), n > 1, n > 1};
      end
      if (int'(s) < w) return {d[int'(s)*8 +: 8], s, 2'b00};
      return {8'h00, s, 2'b10};
   endfunction

   // Drive one cycle of stimulus on instance u and advance the model; returns at negedge.
   task automatic step(input int u, input bit v, input logic [2:0] s, input logic [7:0] h,
                       input logic [63:0] d, input bit r);
      bit acc, cons;
      logic [12:0] e;
      iv[u] = v; sel_s[u] = s; hit_s[u] = h; ind[u] = d; ordy[u] = r;
      acc  = v && (q.size() < 2);
      cons = r && (q.size() > 0);
      e    = ref_entry(u, s, h, d);
      @(posedge clk);
      if (cons) begin
         $display("txn dut%0d out data=%02h way=%0d err=%0b multi=%0b",
                  u, q[0][12:5], q[0][4:2], q[0][1], q[0][0]);
         delivered.push_back(q[0][12:5]);
         void'(q.pop_front());
      end
      if (acc) q.push_back(e);
      #1;
      // Scramble request fields after the edge; stored entries must not follow them.
      sel_s[u] = 3'($urandom); hit_s[u] = 8'($urandom); ind[u] = {$urandom, $urandom};
      @(negedge clk);
   endtask

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   task automatic test_reset();
      logic [14:0] got;
      rst_n = 1'b0; iv = '0; ordy = '0; sel_s = '0; hit_s = '0; ind = '0;
      q.delete();
      repeat (2) @(negedge clk);
      for (int u = 0; u < 3; u++) begin
         got = {ov[u], ir[u], od[u], ow[u], oe[u], om[u]};
         checks++;
         if (got !== {1'b0, 1'b1, 13'h0})
            $display("FAIL reset dut%0d got %04h want %04h", u, got, {1'b0, 1'b1, 13'h0});
         else passed++;
      end
      rst_n = 1'b1;
   endtask

   task automatic test_binary_directed();
      int          u_t[5] = '{0, 1, 1, 1, 0};
      logic [2:0]  s_t[5] = '{3'd5, 3'd7, 3'd6, 3'd3, 3'd0};
      logic [12:0] x_t[5] = '{{8'h15, 3'd5, 2'b00}, {8'h00, 3'd7, 2'b10}, {8'h00, 3'd6, 2'b10},
                             {8'h13, 3'd3, 2'b00}, {8'h10, 3'd0, 2'b00}};
      logic [63:0] d;
      logic [13:0] got;
      for (int i = 0; i < 5; i++) begin
         d = (u_t[i] == 1) ? 64'h0000_1514_1312_1110 : 64'h1716_1514_1312_1110;
         step(u_t[i], 1'b1, s_t[i], 8'h00, d, 1'b1);
         got = {ov[u_t[i]], od[u_t[i]], ow[u_t[i]], oe[u_t[i]], om[u_t[i]]};
         checks++;
         if (got !== {1'b1, x_t[i]})
            $display("FAIL binary dut%0d sel=%0d got %04h want %04h", u_t[i], s_t[i], got, {1'b1, x_t[i]});
         else passed++;
         step(u_t[i], 1'b0, 3'd0, 8'h00, 64'h0, 1'b1);
         checks++;
         if (ov[u_t[i]] !== 1'b0) $display("FAIL binary_drain dut%0d got valid %0b want 0", u_t[i], ov[u_t[i]]);
         else passed++;
      end
   endtask

   task automatic test_onehot_directed();
      logic [7:0]  h_t[5] = '{8'b0010_0100, 8'b0000_0000, 8'b1000_0000, 8'b0000_0001, 8'b1111_1111};
      logic [12:0] x_t[5] = '{{8'h22, 3'd2, 2'b11}, {8'h00, 3'd0, 2'b10}, {8'h27, 3'd7, 2'b00},
                             {8'h20, 3'd0, 2'b00}, {8'h20, 3'd0, 2'b11}};
      logic [13:0] got;
      for (int i = 0; i < 5; i++) begin
         step(2, 1'b1, 3'd0, h_t[i], 64'h2726_2524_2322_2120, 1'b1);
         got = {ov[2], od[2], ow[2], oe[2], om[2]};
         checks++;
         if (got !== {1'b1, x_t[i]})
            $display("FAIL onehot hit=%08b got %04h want %04h", h_t[i], got, {1'b1, x_t[i]});
         else passed++;
      end
      step(2, 1'b0, 3'd0, 8'h00, 64'h0, 1'b1);
   endtask

   task automatic test_backpressure();
      bit         v_t[8] = '{1, 1, 1, 1, 1, 1, 0, 0};
      logic [2:0] s_t[8] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0, 3'd0};
      bit         r_t[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
      logic [7:0] want[3] = '{8'h11, 8'h12, 8'h13};
      logic [14:0] got, exp;
      delivered.delete();
      for (int i = 0; i < 8; i++) begin
         step(0, v_t[i], s_t[i], 8'h00, 64'h1716_1514_1312_1110, r_t[i]);
         got = {ov[0], ir[0], od[0], ow[0], oe[0], om[0]};
         exp = {q.size() > 0, q.size() < 2, 13'h0};
         if (q.size() > 0) exp[12:0] = q[0];
         checks++;
         if (got !== exp) $display("FAIL backpressure step%0d got %04h want %04h", i, got, exp);
         else passed++;
         if (i == 1) begin
            checks++;
            if (ir[0] !== 1'b0) $display("FAIL backpressure_full got in_ready %0b want 0", ir[0]);
            else passed++;
         end
      end
      checks++;
      if (delivered.size() != 3) $display("FAIL backpressure_count got %0d want 3", delivered.size());
      else passed++;
      for (int i = 0; i < 3 && i < delivered.size(); i++) begin
         checks++;
         if (delivered[i] !== want[i])
            $display("FAIL backpressure_order idx%0d got %02h want %02h", i, delivered[i], want[i]);
         else passed++;
      end
   endtask

   task automatic test_throughput();
      logic [14:0] got, exp;
      int ready_low = 0;
      delivered.delete();
      for (int i = 0; i <= 100; i++) begin
         step(0, i < 100, 3'($urandom), 8'h00, rand64(), 1'b1);
         got = {ov[0], ir[0], od[0], ow[0], oe[0], om[0]};
         exp = {q.size() > 0, q.size() < 2, 13'h0};
         if (q.size() > 0) exp[12:0] = q[0];
         checks++;
         if (got !== exp) $display("FAIL throughput cycle%0d got %04h want %04h", i, got, exp);
         else passed++;
         if (ir[0] !== 1'b1) ready_low++;
      end
      checks++;
      if (delivered.size() != 100 || ready_low != 0)
         $display("FAIL throughput_total got %0d results, %0d ready-low cycles want 100, 0",
                  delivered.size(), ready_low);
      else passed++;
   endtask

   task automatic test_random();
      logic [14:0] got, exp;
      logic [7:0]  h;
      for (int u = 0; u < 3; u++) begin
         for (int i = 0; i < 303; i++) begin
            case ($urandom_range(0, 2))
               0:       h = 8'h00;
               1:       h = 8'b1 << $urandom_range(0, 7);
               default: h = 8'($urandom);
            endcase
            if (i < 300)
               step(u, $urandom_range(0, 9) < 7, 3'($urandom), h, rand64(), $urandom_range(0, 9) < 6);
            else
               step(u, 1'b0, 3'd0, 8'h00, 64'h0, 1'b1);
            got = {ov[u], ir[u], od[u], ow[u], oe[u], om[u]};
            exp = {q.size() > 0, q.size() < 2, 13'h0};
            if (q.size() > 0) exp[12:0] = q[0];
            checks++;
            if (got !== exp) $display("FAIL random dut%0d cycle%0d got %04h want %04h", u, i, got, exp);
            else passed++;
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [14:0] got;
      step(0, 1'b1, 3'd4, 8'h00, rand64(), 1'b0);
      step(0, 1'b1, 3'd6, 8'h00, rand64(), 1'b0);
      checks++;
      if (ir[0] !== 1'b0 || ov[0] !== 1'b1)
         $display("FAIL reset_mid_fill got ready=%0b valid=%0b want 0 1", ir[0], ov[0]);
      else passed++;
      iv[0] = 1'b1; ordy[0] = 1'b1; rst_n = 1'b0;
      @(posedge clk);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1; iv[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         got = {ov[0], ir[0], od[0], ow[0], oe[0], om[0]};
         checks++;
         if (got !== {1'b0, 1'b1, 13'h0})
            $display("FAIL reset_mid cycle%0d got %04h want %04h", i, got, {1'b0, 1'b1, 13'h0});
         else passed++;
         step(0, 1'b0, 3'd0, 8'h00, 64'h0, 1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_binary_directed();
      test_onehot_directed();
      test_backpressure();
      test_throughput();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
